// File: rtl/spi_master.sv
// SPI master: WIDTH-bit frames, spi_clk half-period of DIV clk cycles, all four CPOL/CPHA modes.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first transfers; MSB first when undefined.
module spi_master #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             spi_clk_polarity,
   input  logic             spi_clk_phase,
   input  logic             start,
   input  logic [WIDTH-1:0] bus_in,
   output logic [WIDTH-1:0] bus_out,
   output logic             tx,
   output logic             rx,
   output logic             busy,
   output logic             spi_clk,
   output logic             spi_ss,
   output logic             spi_out,
   input  logic             spi_in
);

   localparam int unsigned      CntW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned      EdgeW    = $clog2(2 * WIDTH);
   localparam logic [CntW-1:0]  CntLast  = CntW'(DIV - 1);
   localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(2 * WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StLead, StShift, StTrail} state_e;

   state_e           state_q;
   logic [CntW-1:0]  cnt_q;
   logic [EdgeW-1:0] edge_q;
   logic [WIDTH-1:0] sh_q, rcv_q, bus_out_q;
   logic             cpol_q, cpha_q, spi_clk_q, spi_ss_q, tx_q, rx_q;

   logic             tick, lead_edge, last_edge, do_sample, do_shift;
   logic [WIDTH-1:0] sh_d, rcv_d;

   assign tick      = (cnt_q == CntLast);
   assign lead_edge = ~edge_q[0];
   assign last_edge = (edge_q == EdgeLast);
   // The edge type that does not sample shifts; CPHA=1 keeps the first bit on the first edge.
   assign do_sample = lead_edge ^ cpha_q;
   assign do_shift  = cpha_q ? (lead_edge && (edge_q != '0)) : (!lead_edge && !last_edge);

`ifdef SPI_MASTER_LSB_FIRST_EN
   assign sh_d    = {1'b0, sh_q[WIDTH-1:1]};
   assign rcv_d   = {spi_in, rcv_q[WIDTH-1:1]};
   assign spi_out = sh_q[0];
`else
   assign sh_d    = {sh_q[WIDTH-2:0], 1'b0};
   assign rcv_d   = {rcv_q[WIDTH-2:0], spi_in};
   assign spi_out = sh_q[WIDTH-1];
`endif

   assign bus_out = bus_out_q;
   assign tx      = tx_q;
   assign rx      = rx_q;
   assign busy    = (state_q != StIdle);
   assign spi_clk = spi_clk_q;
   assign spi_ss  = spi_ss_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         edge_q    <= '0;
         sh_q      <= '0;
         rcv_q     <= '0;
         bus_out_q <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         spi_clk_q <= spi_clk_polarity;
         spi_ss_q  <= 1'b1;
         tx_q      <= 1'b0;
         rx_q      <= 1'b0;
      end else begin
         // Pulses last one cycle even if ena drops right after them.
         tx_q <= 1'b0;
         rx_q <= 1'b0;
         if (ena) begin
            unique case (state_q)
               StIdle: begin
                  spi_clk_q <= spi_clk_polarity;
                  if (start) begin
                     state_q  <= StLead;
                     sh_q     <= bus_in;
                     rcv_q    <= '0;
                     cpol_q   <= spi_clk_polarity;
                     cpha_q   <= spi_clk_phase;
                     spi_ss_q <= 1'b0;
                     tx_q     <= 1'b1;
                     cnt_q    <= '0;
                     edge_q   <= '0;
                  end
               end
               StLead: begin
                  if (tick) begin
                     state_q <= StShift;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CntW'(1);
                  end
               end
               StShift: begin
                  if (tick) begin
                     cnt_q     <= '0;
                     spi_clk_q <= ~spi_clk_q;
                     if (do_sample) rcv_q <= rcv_d;
                     if (do_shift) sh_q <= sh_d;
                     if (last_edge) begin
                        state_q   <= StTrail;
                        edge_q    <= '0;
                        spi_clk_q <= cpol_q;
                     end else begin
                        edge_q <= edge_q + EdgeW'(1);
                     end
                  end else begin
                     cnt_q <= cnt_q + CntW'(1);
                  end
               end
               StTrail: begin
                  if (tick) begin
                     state_q   <= StIdle;
                     cnt_q     <= '0;
                     spi_ss_q  <= 1'b1;
                     bus_out_q <= rcv_q;
                     rx_q      <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CntW'(1);
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (WIDTH=8, DIV=2): loopback, slave model in all modes,
// back-to-back frames, clock-enable stretch, mid-frame reset and first-bit ordering.
module tb_spi_master;

   localparam logic [7:0] SlaveWord = 8'h3C;
`ifdef SPI_MASTER_LSB_FIRST_EN
   localparam logic [7:0] OneMosi  = 8'h80;
   localparam logic       OneFirst = 1'b1;
`else
   localparam logic [7:0] OneMosi  = 8'h01;
   localparam logic       OneFirst = 1'b0;
`endif

   logic       clk = 1'b0, rst = 1'b1, ena = 1'b1, cpol = 1'b0, cpha = 1'b0, start = 1'b0;
   logic       loop_mode = 1'b1;
   logic [7:0] bus_in = 8'h00, bus_out;
   logic       tx, rx, busy, spi_clk, spi_ss, spi_out, spi_in;

   int n_tests = 0, n_fail = 0;

   // Monitor / slave model state, written only by the negedge monitor.
   logic       prev_ss = 1'b1, prev_clk = 1'b0, first_lead = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0;
   logic [7:0] miso_sr = 8'h00, mosi_sr = 8'h00;
   int         ss_low_cnt = 0, ss_low_len = 0, ss_high_cnt = 0, gap_len = 0;
   int         edge_cnt = 0, tx_cnt = 0, rx_cnt = 0;

   spi_master #(.WIDTH(8), .DIV(2)) dut (
      .clk              (clk),
      .rst              (rst),
      .ena              (ena),
      .spi_clk_polarity (cpol),
      .spi_clk_phase    (cpha),
      .start            (start),
      .bus_in           (bus_in),
      .bus_out          (bus_out),
      .tx               (tx),
      .rx               (rx),
      .busy             (busy),
      .spi_clk          (spi_clk),
      .spi_ss           (spi_ss),
      .spi_out          (spi_out),
      .spi_in           (spi_in)
   );

   always #5 clk = ~clk;

   assign spi_in = loop_mode ? spi_out : miso_sr[7];

   always @(negedge clk) begin
      prev_ss  <= spi_ss;
      prev_clk <= spi_clk;
      if (tx) tx_cnt <= tx_cnt + 1;
      if (rx) rx_cnt <= rx_cnt + 1;
      if (spi_ss) begin
         if (!prev_ss) begin
            ss_low_len  <= ss_low_cnt;
            ss_high_cnt <= 1;
         end else begin
            ss_high_cnt <= ss_high_cnt + 1;
         end
      end else if (prev_ss) begin
         gap_len    <= ss_high_cnt;
         ss_low_cnt <= 1;
         edge_cnt   <= 0;
         miso_sr    <= SlaveWord;
         mosi_sr    <= 8'h00;
         first_lead <= 1'b1;
         s_cpol     <= cpol;
         s_cpha     <= cpha;
      end else begin
         ss_low_cnt <= ss_low_cnt + 1;
         if (spi_clk != prev_clk) begin
            edge_cnt <= edge_cnt + 1;
            if (spi_clk != s_cpol) begin
               first_lead <= 1'b0;
               if (!s_cpha) mosi_sr <= {mosi_sr[6:0], spi_out};
               else if (!first_lead) miso_sr <= {miso_sr[6:0], 1'b0};
            end else begin
               if (!s_cpha) miso_sr <= {miso_sr[6:0], 1'b0};
               else mosi_sr <= {mosi_sr[6:0], spi_out};
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [7:0] din);
      bus_in = din;
      start  = 1'b1;
      step();
      start  = 1'b0;
   endtask

   task automatic wait_rx(input int budget);
      int n = 0;
      while (rx !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check("rx_seen", 32'(rx), 32'd1);
   endtask

   initial begin
      logic [7:0] exp_b;
      int         frames, txs, txc0, rxc0, n;

      // Reset state, spi_clk follows polarity input under reset and in IDLE.
      step();
      step();
      check("rst_ss", 32'(spi_ss), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bus_out", 32'(bus_out), 32'd0);
      check("rst_tx_rx", 32'({tx, rx}), 32'd0);
      check("rst_spi_out", 32'(spi_out), 32'd0);
      check("rst_clk0", 32'(spi_clk), 32'd0);
      cpol = 1'b1;
      step();
      check("rst_clk1", 32'(spi_clk), 32'd1);
      rst = 1'b0;
      cpol = 1'b0;
      step();
      step();
      check("idle_clk_track", 32'(spi_clk), 32'd0);

      // Loopback 0xA5, mode 0.
      start_frame(8'hA5);
      check("a5_tx", 32'(tx), 32'd1);
      check("a5_ss", 32'(spi_ss), 32'd0);
      check("a5_busy", 32'(busy), 32'd1);
      check("a5_first_bit", 32'(spi_out), 32'd1);
      step();
      check("a5_tx_pulse", 32'(tx), 32'd0);
      wait_rx(100);
      check("a5_bus_out", 32'(bus_out), 32'hA5);
      check("a5_ss_rise", 32'(spi_ss), 32'd1);
      check("a5_ss_low", 32'(ss_low_len), 32'd36);
      check("a5_edges", 32'(edge_cnt), 32'd16);
      step();
      check("a5_rx_pulse", 32'(rx), 32'd0);

      // Slave model in all modes; mode inputs flipped mid-frame must not matter.
      for (int m = 0; m < 4; m++) begin
         cpol = m[1];
         cpha = m[0];
         loop_mode = 1'b0;
         step();
         step();
         start_frame(8'hC3);
         repeat (8) step();
         cpol = ~cpol;
         cpha = ~cpha;
         wait_rx(100);
         check("mode_bus_out", 32'(bus_out), 32'h3C);
         check("mode_mosi", 32'(mosi_sr), 32'hC3);
         check("mode_edges", 32'(edge_cnt), 32'd16);
         check("mode_clk_end", 32'(spi_clk), 32'(m[1]));
         cpol = m[1];
         cpha = m[0];
      end
      cpol = 1'b0;
      cpha = 1'b0;
      loop_mode = 1'b1;
      step();
      step();

      // Back-to-back frames with start held high.
      bus_in = 8'h10;
      exp_b  = 8'h10;
      start  = 1'b1;
      frames = 0;
      txs    = 0;
      n      = 0;
      while (frames < 3 && n < 400) begin
         step();
         n++;
         if (tx) begin
            if (txs > 0) check("b2b_gap", 32'(gap_len), 32'd1);
            txs++;
            bus_in = bus_in + 8'd1;
         end
         if (rx) begin
            check("b2b_data", 32'(bus_out), 32'(exp_b));
            exp_b = exp_b + 8'd1;
            frames++;
         end
      end
      start = 1'b0;
      check("b2b_frames", 32'(frames), 32'd3);
      step();
      step();
      check("b2b_idle", 32'(busy), 32'd0);

      // Start while busy ignored; ena low for 5 cycles stretches the frame.
      start_frame(8'hA5);
      txc0 = tx_cnt;
      step();
      bus_in = 8'hFF;
      start  = 1'b1;
      step();
      start  = 1'b0;
      repeat (6) step();
      ena = 1'b0;
      repeat (5) step();
      ena = 1'b1;
      wait_rx(100);
      check("ena_bus_out", 32'(bus_out), 32'hA5);
      check("ena_ss_low", 32'(ss_low_len), 32'd41);
      check("ena_edges", 32'(edge_cnt), 32'd16);
      check("busy_start_ignored", 32'(tx_cnt), 32'(txc0));
      step();
      step();
      check("no_queued_frame", 32'(busy), 32'd0);

      // Reset during the 4th bit aborts the frame without rx.
      start_frame(8'h3C);
      n = 0;
      while (edge_cnt < 7 && n < 100) begin
         step();
         n++;
      end
      check("rst_mid_reached", 32'(edge_cnt), 32'd7);
      rxc0 = rx_cnt;
      rst  = 1'b1;
      step();
      check("abort_ss", 32'(spi_ss), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_bus_out", 32'(bus_out), 32'd0);
      check("abort_clk", 32'(spi_clk), 32'd0);
      check("abort_spi_out", 32'(spi_out), 32'd0);
      rst = 1'b0;
      repeat (40) step();
      check("abort_no_rx", 32'(rx_cnt), 32'(rxc0));
      check("abort_bus_hold", 32'(bus_out), 32'd0);
      start_frame(8'h5A);
      wait_rx(100);
      check("post_rst_5a", 32'(bus_out), 32'h5A);
      step();

      // Bit order: 0x01 puts its single 1 first (LSB build) or last (MSB build).
      start_frame(8'h01);
      check("one_first_bit", 32'(spi_out), 32'(OneFirst));
      wait_rx(100);
      check("one_bus_out", 32'(bus_out), 32'h01);
      check("one_mosi_order", 32'(mosi_sr), 32'(OneMosi));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter WIDTH, default 8, frame length in bits.
REQ-002 SHALL have parameter DIV, default 4, spi_clk half-period in clk cycles (>=2).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 ena  input  1  clock enable; low freezes all state, counters and outputs.
REQ-007 spi_clk_polarity  input  1  CPOL, idle level of spi_clk.
REQ-008 spi_clk_phase  input  1  CPHA; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-009 start  input  1  request one frame; honoured only in IDLE with ena=1.
REQ-010 bus_in  input  WIDTH  transmit word, captured on accepted start.
REQ-011 bus_out  output  WIDTH  last received word, held until next frame completes.
REQ-012 tx  output  1  one-cycle pulse: bus_in captured, next word may be presented.
REQ-013 rx  output  1  one-cycle pulse: bus_out updated.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 spi_clk, spi_ss, spi_out  output  1 each  serial clock, active-low select, MOSI.
REQ-016 spi_in  input  1  MISO.

Function
REQ-017 States SHALL be IDLE, LEAD, SHIFT, TRAIL; TRAIL -> IDLE unconditionally.
REQ-018 IDLE + start + ena SHALL, next cycle: load shift register from bus_in, latch CPOL/CPHA, pulse tx, drive spi_ss=0, enter LEAD.
REQ-019 spi_out SHALL present the first bit from the cycle spi_ss falls.
REQ-020 Half-period counter SHALL count 0..DIV-1; terminal count = tick; counter clears on every state change.
REQ-021 LEAD SHALL last exactly DIV cycles, spi_clk at latched CPOL.
REQ-022 SHIFT SHALL toggle spi_clk on each tick, exactly 2*WIDTH edges, then enter TRAIL with spi_clk at CPOL.
REQ-023 CPHA=0: leading edges sample spi_in, trailing edges shift out next bit (none after last).
REQ-024 CPHA=1: leading edges shift out next bit (first leading edge keeps first bit), trailing edges sample spi_in.
REQ-025 TRAIL SHALL last exactly DIV cycles; at its end spi_ss=1, bus_out<=received word, rx pulses, state IDLE.
REQ-026 spi_ss low time SHALL be exactly (2*WIDTH+2)*DIV clk cycles.
REQ-027 start while busy SHALL be ignored, not queued; start in the IDLE cycle after TRAIL SHALL be accepted (spi_ss high minimum 1 cycle).
REQ-028 CPOL/CPHA changes during a frame SHALL not affect that frame.
REQ-029 ena low mid-frame SHALL stretch the frame by the number of disabled cycles, no lost or extra edges; tx/rx not asserted while ena low.
REQ-030 Default bit order SHALL be MSB first for both transmit and receive.

Reset
REQ-031 rst SHALL, in any state including mid-frame, force next cycle: IDLE, spi_ss=1, spi_clk=spi_clk_polarity input, spi_out=0, bus_out=0, tx=0, rx=0, busy=0, counters 0.
REQ-032 A frame aborted by rst SHALL not update bus_out or pulse rx.
REQ-033 In IDLE spi_clk SHALL track spi_clk_polarity input.

Configuration
REQ-034 Macro SPI_MASTER_LSB_FIRST_EN defined: transmit and receive LSB first.
REQ-035 Macro undefined: MSB first; all timing identical in both builds.

Verification (WIDTH=8, DIV=2)
REQ-036 CPOL=0 CPHA=0, spi_in tied to spi_out, bus_in=0xA5, start -> tx 1 cycle after start, 16 spi_clk edges, spi_ss low 36 cycles, bus_out=0xA5 with rx on spi_ss rise.
REQ-037 All four CPOL/CPHA modes, spi_in driven by bench model returning 0x3C -> bus_out=0x3C, spi_out sampled by model = bus_in=0xC3 each mode.
REQ-038 start held high continuously, bus_in incrementing on tx -> back-to-back frames, spi_ss high exactly 1 cycle between frames, no start lost in IDLE.
REQ-039 ena low 5 cycles mid-SHIFT -> spi_ss low 41 cycles, data still 0xA5 loopback correct.
REQ-040 rst asserted during 4th bit -> next cycle spi_ss=1, busy=0, bus_out=0, no rx; subsequent frame 0x5A loops back correctly.
REQ-041 SPI_MASTER_LSB_FIRST_EN build, bus_in=0x01 -> spi_out high on first bit only; loopback returns 0x01.
